// File: rtl/pixel_fifo_pkg.sv
// pixel_fifo_pkg: shared types and constants for the pixel FIFO.
// Entry layout is {source, mode, proc_val, data}.
package pixel_fifo_pkg;

  localparam int DEFAULT_DW = 32;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_SCALE = 2'd1;
  localparam logic [1:0] MODE_BLEND = 2'd2;
  localparam logic [1:0] MODE_MASK  = 2'd3;

  typedef struct packed {
    logic       source;
    logic [1:0] mode;
    logic [7:0] proc_val;
  } tag_t;

  typedef struct packed {
    logic                  source;
    logic [1:0]            mode;
    logic [7:0]            proc_val;
    logic [DEFAULT_DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/pixel_fifo_if.sv
// pixel_fifo_if: arbiter write strobe plus master-side head handshake.
// slave = FIFO view, master = arbiter/consumer view.
interface pixel_fifo_if #(
  parameter int DW = 32
);

  logic          slvx_data_valid;
  logic [DW-1:0] slvx_data;
  logic [1:0]    slvx_mode;
  logic [7:0]    slvx_proc_val;
  logic          data_source;
  logic          fifo_full;

  logic          mstr_valid;
  logic          mstr_ready;
  logic [DW-1:0] mstr_data;
  logic [1:0]    mstr_mode;
  logic [7:0]    mstr_proc_val;
  logic          mstr_source;

  modport slave (
    input  slvx_data_valid,
    input  slvx_data,
    input  slvx_mode,
    input  slvx_proc_val,
    input  data_source,
    output fifo_full,
    output mstr_valid,
    input  mstr_ready,
    output mstr_data,
    output mstr_mode,
    output mstr_proc_val,
    output mstr_source
  );

  modport master (
    output slvx_data_valid,
    output slvx_data,
    output slvx_mode,
    output slvx_proc_val,
    output data_source,
    input  fifo_full,
    input  mstr_valid,
    output mstr_ready,
    input  mstr_data,
    input  mstr_mode,
    input  mstr_proc_val,
    input  mstr_source
  );

endinterface

// File: rtl/pixel_fifo_mem.sv
// pixel_fifo_mem: 1W/1R storage, async read, contents never reset.
// Read data follows raddr combinationally for fall-through heads.
module pixel_fifo_mem #(
  parameter int W     = 43,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // write port, no reset on the array
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_fifo.sv
// pixel_fifo: FWFT pixel FIFO with frame-complete pulse and overflow flag.
// Optional almost_full output under PIXEL_FIFO_ALMOST_FULL_EN.
module pixel_fifo
  import pixel_fifo_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pixel_fifo_if.slave            bus,
  input  logic [15:0]            frame_len,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   mstr0_cmplt,
`ifdef PIXEL_FIFO_ALMOST_FULL_EN
  output logic                   almost_full,
`endif
  output logic                   overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $bits(tag_t);
  localparam int EW = TW + DW;

  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   fcnt;
  logic          cmplt_q;
  logic          ovf_q;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic          frame_on;
  logic          frame_end;

  tag_t          wr_tag;
  tag_t          rd_tag;
  logic [DW-1:0] rd_data;
  logic [EW-1:0] wr_word;
  logic [EW-1:0] rd_word;

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);
  assign push  = bus.slvx_data_valid & ~full;
  assign drop  = bus.slvx_data_valid & full;
  assign pop   = ~empty & bus.mstr_ready;

  assign frame_on  = (frame_len != 16'd0);
  assign frame_end = pop & frame_on &
                     (fcnt == frame_len - 16'd1);

  assign wr_tag.source   = bus.data_source;
  assign wr_tag.mode     = bus.slvx_mode;
  assign wr_tag.proc_val = bus.slvx_proc_val;
  assign wr_word         = {wr_tag, bus.slvx_data};

  pixel_fifo_mem #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_word),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  assign {rd_tag, rd_data} = rd_word;

  // pointers advance on accepted push/pop; extra MSB wraps freely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // occupancy: push and pop together leave it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // frame counter and one-cycle completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt    <= '0;
      cmplt_q <= 1'b0;
    end else begin
      cmplt_q <= frame_end;
      if (!frame_on) begin
        fcnt <= '0;
      end else if (frame_end) begin
        fcnt <= '0;
      end else if (pop) begin
        fcnt <= fcnt + 16'd1;
      end
    end
  end

  // sticky flag for any write dropped while full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.fifo_full     = full;
  assign bus.mstr_valid    = ~empty;
  assign bus.mstr_data     = empty ? '0 : rd_data;
  assign bus.mstr_mode     = empty ? '0 : rd_tag.mode;
  assign bus.mstr_proc_val = empty ? '0 : rd_tag.proc_val;
  assign bus.mstr_source   = empty ? 1'b0 : rd_tag.source;

  assign fifo_count   = count;
  assign mstr0_cmplt  = cmplt_q;
  assign overflow_err = ovf_q;

`ifdef PIXEL_FIFO_ALMOST_FULL_EN
  assign almost_full = (count >= CW'(DEPTH - 2));
`endif

endmodule

// File: tb/tb_pixel_fifo.sv
// tb_pixel_fifo: queue-based reference model, directed plus random traffic.
// Outputs compared against the model at every falling edge.
module tb_pixel_fifo;
  import pixel_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   frame_len = 16'd0;
  logic [CW-1:0] fifo_count;
  logic          mstr0_cmplt;
  logic          overflow_err;
`ifdef PIXEL_FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif

  pixel_fifo_if #(.DW(DW)) bus ();

  pixel_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .frame_len    (frame_len),
    .fifo_count   (fifo_count),
    .mstr0_cmplt  (mstr0_cmplt),
`ifdef PIXEL_FIFO_ALMOST_FULL_EN
    .almost_full  (almost_full),
`endif
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  entry_t      q[$];
  logic [15:0] m_fcnt;
  bit          m_cmplt;
  bit          m_ovf;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_fcnt  = '0;
    m_cmplt = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step();
    bit     full;
    bit     do_pop;
    entry_t e;
    full    = (q.size() == DEPTH);
    do_pop  = (q.size() != 0) && bus.mstr_ready;
    m_cmplt = 1'b0;
    if (bus.slvx_data_valid && full) m_ovf = 1'b1;
    if (do_pop) void'(q.pop_front());
    if (frame_len == 16'd0) begin
      m_fcnt = '0;
    end else if (do_pop) begin
      if (m_fcnt == frame_len - 16'd1) begin
        m_fcnt  = '0;
        m_cmplt = 1'b1;
      end else begin
        m_fcnt = m_fcnt + 16'd1;
      end
    end
    if (bus.slvx_data_valid && !full) begin
      e.source   = bus.data_source;
      e.mode     = bus.slvx_mode;
      e.proc_val = bus.slvx_proc_val;
      e.data     = bus.slvx_data;
      q.push_back(e);
    end
  endtask

  task automatic compare();
    entry_t e;
    bit     v;
    v = (q.size() != 0);
    e = v ? q[0] : '0;
    chk("mstr_valid", bus.mstr_valid, v);
    chk("mstr_data", bus.mstr_data, e.data);
    chk("mstr_mode", bus.mstr_mode, e.mode);
    chk("mstr_proc_val", bus.mstr_proc_val, e.proc_val);
    chk("mstr_source", bus.mstr_source, e.source);
    chk("fifo_count", fifo_count, q.size());
    chk("fifo_full", bus.fifo_full, q.size() == DEPTH);
    chk("mstr0_cmplt", mstr0_cmplt, m_cmplt);
    chk("overflow_err", overflow_err, m_ovf);
`ifdef PIXEL_FIFO_ALMOST_FULL_EN
    chk("almost_full", almost_full, q.size() >= DEPTH - 2);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    #1;
  endtask

  task automatic set_in(bit v, logic [31:0] d, logic [1:0] m,
                        logic [7:0] p, bit s, bit r);
    bus.slvx_data_valid = v;
    bus.slvx_data       = d;
    bus.slvx_mode       = m;
    bus.slvx_proc_val   = p;
    bus.data_source     = s;
    bus.mstr_ready      = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    compare();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8:0] pat9;
    logic [4:0] pat5;
    int pv;
    int pr;
    set_in(0, '0, '0, '0, 0, 0);
    model_clear();

    // reset state
    do_reset();
    chk("rst_valid", bus.mstr_valid, 1'b0);
    chk("rst_count", fifo_count, 0);
    chk("rst_full", bus.fifo_full, 1'b0);
    chk("rst_ovf", overflow_err, 1'b0);

    // first push right after reset release, fall-through head
    set_in(1, 32'hA5A5_0001, 2'd1, 8'h10, 0, 0);
    tick();
    chk("fwft_valid", bus.mstr_valid, 1'b1);
    chk("fwft_data", bus.mstr_data, 32'hA5A5_0001);
    chk("fwft_mode", bus.mstr_mode, 2'd1);
    chk("fwft_proc", bus.mstr_proc_val, 8'h10);
    chk("fwft_count", fifo_count, 1);

    // fill to full
    for (int i = 2; i <= 16; i++) begin
      set_in(1, 32'hA5A5_0000 + i, i[1:0], i[7:0], i[0], 0);
      tick();
`ifdef PIXEL_FIFO_ALMOST_FULL_EN
      if (i == 13) chk("af_13", almost_full, 1'b0);
      if (i == 14) chk("af_14", almost_full, 1'b1);
`endif
    end
    chk("full_flag", bus.fifo_full, 1'b1);
    chk("full_count", fifo_count, 16);

    // 17th push dropped
    set_in(1, 32'hDEAD_BEEF, 2'd3, 8'hFF, 1, 0);
    tick();
    chk("drop_count", fifo_count, 16);
    chk("drop_ovf", overflow_err, 1'b1);
    chk("drop_head", bus.mstr_data, 32'hA5A5_0001);

    // full + push + pop: write dropped, count 15
    set_in(1, 32'hBAD0_0000, 2'd2, 8'h55, 1, 1);
    tick();
    chk("fpp_count", fifo_count, 15);
    chk("fpp_head", bus.mstr_data, 32'hA5A5_0002);

    // drain, order checked by model each cycle
    set_in(0, '0, '0, '0, 0, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("drain_valid", bus.mstr_valid, 1'b0);
    chk("drain_data", bus.mstr_data, 0);

    // 5 queued, reset mid-cycle clears immediately
    for (int i = 0; i < 5; i++) begin
      set_in(1, 32'h0C0C_0000 + i, 2'd0, 8'h01, 1, 0);
      tick();
    end
    set_in(0, '0, '0, '0, 0, 0);
    chk("pre_rst_count", fifo_count, 5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_valid", bus.mstr_valid, 1'b0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ovf", overflow_err, 1'b0);
    chk("mid_rst_data", bus.mstr_data, 0);
    compare();
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // frame_len=4, 8 pops back to back
    frame_len = 16'd4;
    for (int i = 0; i < 8; i++) begin
      set_in(1, 32'hF000_0000 + i, 2'd1, 8'h20, 0, 0);
      tick();
    end
    set_in(0, '0, '0, '0, 0, 1);
    for (int k = 0; k < 9; k++) begin
      tick();
      pat9[k] = mstr0_cmplt;
    end
    chk("frame_pulses", pat9, 9'b0_1000_1000);

    // counter back at 0: next 4 pops complete a frame
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'hF100_0000 + i, 2'd2, 8'h30, 1, 0);
      tick();
    end
    set_in(0, '0, '0, '0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      pat5[k] = mstr0_cmplt;
    end
    chk("frame_restart", pat5, 5'b0_1000);

    // frame_len=0: no pulses
    frame_len = 16'd0;
    for (int i = 0; i < 6; i++) begin
      set_in(1, $urandom, 2'd0, 8'h00, 0, 1);
      tick();
    end

    // random traffic segments
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      frame_len = 16'($urandom_range(0, 5));
      unique case (seg)
        0: begin pv = 70; pr = 30; end
        1: begin pv = 30; pr = 70; end
        2: begin pv = 90; pr = 90; end
        default: begin pv = 50; pr = 50; end
      endcase
      for (int n = 0; n < 500; n++) begin
        set_in($urandom_range(0, 99) < pv, $urandom,
               2'($urandom), 8'($urandom), 1'($urandom),
               $urandom_range(0, 99) < pr);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
